// File: rtl/gpr_bus_sched.sv
// gpr_bus_sched: bus scheduler for the tri-state general-purpose register file.
// Grants one-hot read enables on operand buses A/B and write/pass-through enables
// on bus C. A pending-write scoreboard stalls issue on RAW/WAW hazards.
// Optional build macro GPR_SCHED_FWD_EN: a source whose pending write lands on
// bus C in the issue cycle is forwarded (fwd_A/fwd_B) rather than stalled.
module gpr_bus_sched #(
  parameter int NREG = 32,
  parameter int IDXW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [IDXW-1:0] iss_rs1,
  input  logic [IDXW-1:0] iss_rs2,
  input  logic            iss_use_rs1,
  input  logic            iss_use_rs2,
  input  logic [IDXW-1:0] iss_rd,
  input  logic            iss_rd_we,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [NREG-1:0] rd_A_en,
  output logic [NREG-1:0] rd_B_en,
  input  logic            wb_valid,
  input  logic [IDXW-1:0] wb_rd,
  input  logic            wb_thru,
  output logic [NREG-1:0] wt_en,
  output logic [NREG-1:0] through_C_en,
  output logic [NREG-1:0] pend,
  output logic            sb_err
`ifdef GPR_SCHED_FWD_EN
  ,
  output logic            fwd_A,
  output logic            fwd_B
`endif
);

  typedef enum logic {IDLE, OPND} state_t;

  localparam logic [IDXW:0] NREG_W = (IDXW+1)'(NREG);

  state_t          state, state_nxt;
  logic [IDXW-1:0] rs1_q, rs2_q;
  logic            use1_q, use2_q;
  logic            fwd1_q, fwd2_q;
  logic [NREG-1:0] pend_q;
  logic            err_q;

  logic            fwd_ok, fwd1_now, fwd2_now;
  logic            hazard, accept, err_set;
  logic [NREG-1:0] pend_set, pend_clr;

  // Indices at or beyond NREG shift out and yield an all-zero vector.
  function automatic logic [NREG-1:0] onehot(input logic [IDXW-1:0] idx);
    return {{(NREG-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic in_range(input logic [IDXW-1:0] idx);
    return {1'b0, idx} < NREG_W;
  endfunction

  function automatic logic pend_hit(input logic [IDXW-1:0] idx);
    return |(pend_q & onehot(idx));
  endfunction

`ifdef GPR_SCHED_FWD_EN
  assign fwd_ok = wb_valid & wb_thru;
  assign fwd_A  = op_valid & fwd1_q;
  assign fwd_B  = op_valid & fwd2_q;
`else
  assign fwd_ok = 1'b0;
`endif

  // A pending source being written through bus C this cycle can be captured instead of read.
  assign fwd1_now = fwd_ok & iss_use_rs1 & pend_hit(iss_rs1) & (wb_rd == iss_rs1);
  assign fwd2_now = fwd_ok & iss_use_rs2 & pend_hit(iss_rs2) & (wb_rd == iss_rs2);

  // Hazards look at the scoreboard before this cycle's writeback clears it; bit 0 is never pending.
  assign hazard = (iss_use_rs1 & pend_hit(iss_rs1) & ~fwd1_now)
                | (iss_use_rs2 & pend_hit(iss_rs2) & ~fwd2_now)
                | (iss_rd_we   & pend_hit(iss_rd));

  assign iss_ready = ~hazard & ((state == IDLE) | op_ready);
  assign accept    = iss_valid & iss_ready;

  assign pend_set = (accept & iss_rd_we & (iss_rd != '0)) ? onehot(iss_rd) : '0;
  assign pend_clr = wb_valid ? onehot(wb_rd) : '0;

  assign err_set = (wb_valid & (wb_rd != '0) & ~pend_hit(wb_rd))
                 | (wb_valid & ~in_range(wb_rd))
                 | (iss_valid & ~(in_range(iss_rs1) & in_range(iss_rs2) & in_range(iss_rd)));

  // Operand enables are decoded from registered state only, so they change just after a clock edge.
  assign op_valid     = (state == OPND);
  assign rd_A_en      = (op_valid & use1_q & ~fwd1_q) ? onehot(rs1_q) : '0;
  assign rd_B_en      = (op_valid & use2_q & ~fwd2_q) ? onehot(rs2_q) : '0;
  assign wt_en        = wb_valid ? onehot(wb_rd) : '0;
  assign through_C_en = (wb_valid & wb_thru) ? onehot(wb_rd) : '0;
  assign pend         = pend_q;
  assign sb_err       = err_q;

  // State register for the operand-phase FSM.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: enter or stay in OPND on accept, drop back to IDLE once operands are consumed.
  always_comb begin
    // NOTE: the default comes first so no path leaves state_nxt unassigned and infers a latch.
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = OPND;
      OPND: if (accept) state_nxt = OPND;
            else if (op_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the accepted instruction's source operands for the following operand phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_q  <= '0;
      rs2_q  <= '0;
      use1_q <= 1'b0;
      use2_q <= 1'b0;
      fwd1_q <= 1'b0;
      fwd2_q <= 1'b0;
    end else if (accept) begin
      rs1_q  <= iss_rs1;
      rs2_q  <= iss_rs2;
      use1_q <= iss_use_rs1;
      use2_q <= iss_use_rs2;
      fwd1_q <= fwd1_now;
      fwd2_q <= fwd2_now;
    end
  end

  // Scoreboard and sticky error: a same-index set beats the writeback clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= (pend_q & ~pend_clr) | pend_set;
      err_q  <= err_q | err_set;
    end
  end

endmodule

// File: doc/gpr_bus_sched.md
Name: gpr_bus_sched

Overview:
- Controller for the tri-state general-purpose register file (GPR0 plus GPR1..GPR31), which sits on operand buses A and B and writeback bus C.
- Accepts instruction-issue requests from decode and writeback requests from execute.
- Drives the one-hot per-register enables rd_A_en, rd_B_en, wt_en and through_C_en, so at most one register drives each bus per cycle.
- Holds a pending-write scoreboard and stalls issue on RAW/WAW hazards.

Parameters:
- NREG, 32: number of registers; register 0 is hard-wired zero.
- IDXW, 5: register index width, log2(NREG).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- iss_valid  in  1  decode issue request.
- iss_ready  out  1  issue accepted this cycle when high together with iss_valid.
- iss_rs1  in  IDXW  source A index.
- iss_rs2  in  IDXW  source B index.
- iss_use_rs1  in  1  source A is used.
- iss_use_rs2  in  1  source B is used.
- iss_rd  in  IDXW  destination index.
- iss_rd_we  in  1  instruction writes rd.
- op_valid  out  1  operand phase active; buses A/B are driven.
- op_ready  in  1  execute has consumed the operands.
- rd_A_en  out  NREG  one-hot bus A read enables.
- rd_B_en  out  NREG  one-hot bus B read enables.
- wb_valid  in  1  writeback this cycle.
- wb_rd  in  IDXW  writeback destination.
- wb_thru  in  1  also pass the written data onto bus C.
- wt_en  out  NREG  one-hot write enables.
- through_C_en  out  NREG  one-hot bus C pass-through enables.
- pend  out  NREG  scoreboard state, for debug.
- sb_err  out  1  sticky error flag.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; pend=0; sb_err=0.
  - op_valid=0; rd_A_en=rd_B_en=0; latched operand indices=0.
- Hazard, evaluated combinationally on the pending state before this cycle's writeback clear:
  - (iss_use_rs1 & pend[iss_rs1]), or
  - (iss_use_rs2 & pend[iss_rs2]), or
  - (iss_rd_we & pend[iss_rd]).
  - Index 0 never causes a hazard.
- FSM states: IDLE, OPND.
  - iss_ready = ~hazard & (state==IDLE | op_ready). The OPND state is left by op_ready.
  - Accept = iss_valid & iss_ready.
  - Accept latches rs1/rs2/use flags and moves to OPND on the next cycle.
  - OPND with op_ready=1 and no accept: go to IDLE.
  - OPND with op_ready=1 and accept: stay in OPND with the new operands (back-to-back, one issue per cycle).
  - OPND with op_ready=0: hold OPND and keep the buses driven.
- Operand outputs (registered):
  - op_valid = (state==OPND).
  - rd_A_en = op_valid & use_rs1 ? onehot(rs1) : 0.
  - rd_B_en works the same way for rs2.
  - A read of r0 still asserts bit 0; GPR0 drives zero.
  - Latency: accept at cycle N gives enables and op_valid at cycle N+1.
- Scoreboard:
  - Accept with iss_rd_we & iss_rd!=0 sets pend[iss_rd] at the edge.
  - wb_valid clears pend[wb_rd] at the edge.
  - If a set and a clear hit the same index in the same cycle, the set wins.
- Write outputs (combinational, same cycle as wb_valid):
  - wt_en = wb_valid ? onehot(wb_rd) : 0.
  - through_C_en = wb_valid & wb_thru ? onehot(wb_rd) : 0.
  - A write to r0 still pulses bit 0 and has no effect on the scoreboard.
- sb_err is set, and stays set until reset, on:
  - wb_valid with wb_rd!=0 & ~pend[wb_rd]; or
  - an index >= NREG on any port.
- Mid-operation reset: outstanding operand phase and all pending bits are dropped; the next cycle is IDLE with all outputs 0.

Optional Feature:
- Macro: GPR_SCHED_FWD_EN.
- With the macro defined:
  - A source hazard whose index equals wb_rd while wb_valid=1 and wb_thru=1 is not a hazard.
  - The instruction is accepted, and the matching rd_A_en/rd_B_en bit is suppressed in OPND.
  - New outputs fwd_A/fwd_B (1 bit each) go high during OPND, selecting the captured bus C value.
  - A WAW hazard on rd still stalls.
- Without the macro: fwd_A/fwd_B are absent and every pending source stalls.

Test Plan:
- Reset, then issue rs1=3, rs2=5, rd=7 (we) with op_ready=1 -> next cycle rd_A_en=0x8, rd_B_en=0x20, op_valid=1, pend=0x80; one cycle later op_valid=0.
- With pend[7]=1, issue rs1=7 -> iss_ready=0 until wb_valid with wb_rd=7 and wt_en=0x80; the issue is accepted on the following cycle.
- Issue rd=0 (we), then wb_rd=0 -> pend stays 0, wt_en=0x1, sb_err=0.
- In the same cycle, accept rd=4 and wb_rd=4 -> pend[4]=1 after the edge.
- Hold op_ready=0 for 3 cycles in OPND -> enables stable, iss_ready=0; release -> back-to-back accept with no bubble.
- wb_rd=9 while not pending -> sb_err=1 and sticky; assert rst mid-OPND -> next cycle all outputs 0, including sb_err. With GPR_SCHED_FWD_EN: rs1=9 pending and wb_rd=9 with wb_thru=1 -> accepted, rd_A_en=0, fwd_A=1.
